// File: rtl/crypto_bus_pkg.sv
// Shared encodings for the crypto core register bus: request opcodes,
// controller FSM states and the default bus data width.
package crypto_bus_pkg;

    localparam int DATA_W_DEF = 16;

    // Host request opcodes
    localparam logic [1:0] OP_MOVE = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_READ = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    // Bus controller FSM states
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RD_ISSUE = 3'd1;
    localparam logic [2:0] ST_RD_CAPT  = 3'd2;
    localparam logic [2:0] ST_WR       = 3'd3;
    localparam logic [2:0] ST_SCRUB    = 3'd4;
    localparam logic [2:0] ST_RESP     = 3'd5;

    // True for the three opcodes the controller knows how to sequence.
    function automatic logic op_known(input logic [1:0] op);
        return (op != OP_RSVD);
    endfunction

endpackage

// File: rtl/reg_rdata_mux.sv
// NUM_REGS:1 selector over the flattened register read-data bus.
module reg_rdata_mux
    import crypto_bus_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic [NUM_REGS*DATA_W-1:0] bus_rdata,
    input  logic [IDX_W-1:0]           sel,
    output logic [DATA_W-1:0]          data
);

    // Pick the addressed slot; an index with no slot behind it yields zero.
    always_comb begin
        data = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            data = (sel == IDX_W'(i)) ? bus_rdata[i*DATA_W +: DATA_W] : data;
        end
    end

endmodule

// File: rtl/reg_bus_ctrl.sv
// Register-bus initiator for the crypto core register file. Sequences one
// host request (MOVE / LOAD / READ) at a time into one-hot send/save strobes.
// Optional feature: define REG_BUS_CTRL_SCRUB_EN to zero the source register
// after it has been consumed by a MOVE (src != dst) or a READ.
module reg_bus_ctrl
    import crypto_bus_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [1:0]                 req_op,
    input  logic [IDX_W-1:0]           req_src,
    input  logic [IDX_W-1:0]           req_dst,
    input  logic [DATA_W-1:0]          req_imm,
    output logic [NUM_REGS-1:0]        send_info_bus,
    output logic [NUM_REGS-1:0]        save_info_bus,
    output logic [DATA_W-1:0]          bus_wdata,
    input  logic [NUM_REGS*DATA_W-1:0] bus_rdata,
    output logic                       rsp_valid,
    output logic [DATA_W-1:0]          rsp_data,
    output logic                       rsp_err
);

    localparam logic [NUM_REGS-1:0] ONE_LSB = {{(NUM_REGS-1){1'b0}}, 1'b1};
    localparam logic [NUM_REGS-1:0] NO_REGS = {NUM_REGS{1'b0}};

    logic [2:0]          state_r;
    logic [2:0]          state_nxt_s;
    logic [1:0]          op_r;
    logic [IDX_W-1:0]    src_r;
    logic [IDX_W-1:0]    dst_r;
    logic                req_ready_r;
    logic [NUM_REGS-1:0] send_r;
    logic [NUM_REGS-1:0] save_r;
    logic [DATA_W-1:0]   wdata_r;
    logic                rsp_valid_r;
    logic [DATA_W-1:0]   rsp_data_r;
    logic                rsp_err_r;

    logic                accept_s;
    logic                req_bad_s;
    logic [NUM_REGS-1:0] req_src_oh_s;
    logic [NUM_REGS-1:0] req_dst_oh_s;
    logic [NUM_REGS-1:0] src_oh_s;
    logic [NUM_REGS-1:0] dst_oh_s;
    logic [NUM_REGS-1:0] send_nxt_s;
    logic [NUM_REGS-1:0] save_nxt_s;
    logic [DATA_W-1:0]   wdata_nxt_s;
    logic [DATA_W-1:0]   mux_data_s;

    // An index with no register behind it decodes to an all-zero one-hot,
    // which doubles as the out-of-range check.
    assign req_src_oh_s = ONE_LSB << req_src;
    assign req_dst_oh_s = ONE_LSB << req_dst;
    assign src_oh_s     = ONE_LSB << src_r;
    assign dst_oh_s     = ONE_LSB << dst_r;

    assign accept_s  = req_valid && req_ready_r;
    assign req_bad_s = !op_known(req_op) || (req_src_oh_s == NO_REGS) || (req_dst_oh_s == NO_REGS);

    reg_rdata_mux #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W),
        .IDX_W    (IDX_W)
    ) u_rdata_mux (
        .bus_rdata (bus_rdata),
        .sel       (src_r),
        .data      (mux_data_s)
    );

    // Next-state sequencing of the accepted request.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!accept_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (req_bad_s) begin
                    state_nxt_s = ST_RESP;
                end else if (req_op == OP_LOAD) begin
                    state_nxt_s = ST_WR;
                end else begin
                    state_nxt_s = ST_RD_ISSUE;
                end
            end
            ST_RD_ISSUE: state_nxt_s = ST_RD_CAPT;
            ST_RD_CAPT: begin
                if (op_r == OP_MOVE) begin
                    state_nxt_s = ST_WR;
                end else begin
`ifdef REG_BUS_CTRL_SCRUB_EN
                    state_nxt_s = ST_SCRUB;
`else
                    state_nxt_s = ST_RESP;
`endif
                end
            end
            ST_WR: begin
`ifdef REG_BUS_CTRL_SCRUB_EN
                // Writing back onto itself leaves nothing to scrub.
                if ((op_r == OP_MOVE) && (src_r != dst_r)) begin
                    state_nxt_s = ST_SCRUB;
                end else begin
                    state_nxt_s = ST_RESP;
                end
`else
                state_nxt_s = ST_RESP;
`endif
            end
`ifdef REG_BUS_CTRL_SCRUB_EN
            ST_SCRUB: state_nxt_s = ST_RESP;
`endif
            ST_RESP: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Strobe and write-data values for the state being entered; the bus data
    // is driven to zero whenever no write is in progress.
    always_comb begin
        send_nxt_s  = NO_REGS;
        save_nxt_s  = NO_REGS;
        wdata_nxt_s = {DATA_W{1'b0}};
        case (state_nxt_s)
            ST_RD_ISSUE: send_nxt_s = req_src_oh_s;
            ST_WR: begin
                if (state_r == ST_IDLE) begin
                    save_nxt_s  = req_dst_oh_s;
                    wdata_nxt_s = req_imm;
                end else begin
                    save_nxt_s  = dst_oh_s;
                    wdata_nxt_s = mux_data_s;
                end
            end
`ifdef REG_BUS_CTRL_SCRUB_EN
            ST_SCRUB: save_nxt_s = src_oh_s;
`endif
            default: send_nxt_s = NO_REGS;
        endcase
    end

    // State, request capture, bus strobes and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            op_r        <= OP_MOVE;
            src_r       <= {IDX_W{1'b0}};
            dst_r       <= {IDX_W{1'b0}};
            req_ready_r <= 1'b1;
            send_r      <= NO_REGS;
            save_r      <= NO_REGS;
            wdata_r     <= {DATA_W{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= {DATA_W{1'b0}};
            rsp_err_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            req_ready_r <= (state_nxt_s == ST_IDLE);
            send_r      <= send_nxt_s;
            save_r      <= save_nxt_s;
            wdata_r     <= wdata_nxt_s;
            rsp_valid_r <= (state_nxt_s == ST_RESP);
            // Only a rejected request jumps straight from IDLE to RESP.
            rsp_err_r   <= (state_nxt_s == ST_RESP) && (state_r == ST_IDLE);
            if (accept_s) begin
                op_r  <= req_op;
                src_r <= req_src;
                dst_r <= req_dst;
            end
            if ((state_r == ST_RD_CAPT) && (op_r == OP_READ)) begin
                rsp_data_r <= mux_data_s;
            end
        end
    end

    assign req_ready     = req_ready_r;
    assign send_info_bus = send_r;
    assign save_info_bus = save_r;
    assign bus_wdata     = wdata_r;
    assign rsp_valid     = rsp_valid_r;
    assign rsp_data      = rsp_data_r;
    assign rsp_err       = rsp_err_r;

endmodule

// File: tb/tb_reg_bus_ctrl.sv
// Bench for reg_bus_ctrl: behavioural register file on the bus, reference
// register model, and a response scoreboard checked on the falling edge.
module tb_reg_bus_ctrl;
    import crypto_bus_pkg::*;

    localparam int NR = 8;
    localparam int DW = 16;
    localparam int IW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, mdl_init;
    logic           req_valid, req_ready, req_valid6, req_ready6;
    logic [1:0]     req_op;
    logic [IW-1:0]  req_src, req_dst;
    logic [DW-1:0]  req_imm;
    logic [NR-1:0]  send_info_bus, save_info_bus;
    logic [DW-1:0]  bus_wdata, rsp_data;
    logic [NR*DW-1:0] bus_rdata;
    logic           rsp_valid, rsp_err;
    logic [5:0]     send6, save6;
    logic [DW-1:0]  wdata6, rsp_data6;
    logic [6*DW-1:0] rdata6;
    logic           rsp_valid6, rsp_err6;

    assign rdata6 = {(6*DW){1'b0}};

    reg_bus_ctrl #(.NUM_REGS(NR), .DATA_W(DW), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_src(req_src), .req_dst(req_dst), .req_imm(req_imm),
        .send_info_bus(send_info_bus), .save_info_bus(save_info_bus),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    // Six-slot instance used only for the out-of-range index case.
    reg_bus_ctrl #(.NUM_REGS(6), .DATA_W(DW), .IDX_W(3)) dut6 (
        .clk(clk), .rst(rst), .req_valid(req_valid6), .req_ready(req_ready6),
        .req_op(req_op), .req_src(req_src), .req_dst(req_dst), .req_imm(req_imm),
        .send_info_bus(send6), .save_info_bus(save6),
        .bus_wdata(wdata6), .bus_rdata(rdata6),
        .rsp_valid(rsp_valid6), .rsp_data(rsp_data6), .rsp_err(rsp_err6)
    );

    // Register file on the bus: send -> data next cycle, save -> latch.
    logic [DW-1:0] mem [NR];
    always @(posedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (mdl_init) begin
                mem[i] <= 16'h1000 + 16'(i);
                bus_rdata[i*DW +: DW] <= 16'h0000;
            end else begin
                if (send_info_bus[i]) bus_rdata[i*DW +: DW] <= mem[i];
                if (save_info_bus[i]) mem[i] <= bus_wdata;
            end
        end
    end

    typedef struct { logic err; logic [DW-1:0] data; int due; } exp_t;
    typedef struct { logic [1:0] op; logic [2:0] src; logic [2:0] dst; logic [15:0] imm; logic err; } vec_t;

    exp_t          sbq[$];
    logic [DW-1:0] ref_regs [NR];
    logic [DW-1:0] exp_rsp_data;
    int            n_vec = 0;
    int            n_bad = 0;
    int            cyc = 0;
    vec_t          vt [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One clock: scoreboard and strobe monitor on the falling edge, return #1 after the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (rsp_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL unexpected_rsp: rsp_valid=1 at cycle %0d, required no response", cyc);
            end else begin
                e = sbq.pop_front();
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
                chk("rsp_data", 32'(rsp_data), 32'(e.data));
                chk("rsp_cycle", 32'(cyc), 32'(e.due));
            end
        end
        if ((send_info_bus | save_info_bus) != 8'h00) begin
            n_vec++;
            if (!$onehot0(send_info_bus) || !$onehot0(save_info_bus) ||
                ((send_info_bus != 8'h00) && (save_info_bus != 8'h00))) begin
                n_bad++;
                $display("FAIL strobe_shape: send=%b save=%b, required one-hot and not both", send_info_bus, save_info_bus);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic int lat_of(input logic [1:0] op, input logic [2:0] src, input logic [2:0] dst, input logic err);
        int l;
        if (err) return 1;
        case (op)
            OP_MOVE: l = 4;
            OP_READ: l = 3;
            default: l = 2;
        endcase
`ifdef REG_BUS_CTRL_SCRUB_EN
        if ((op == OP_READ) || ((op == OP_MOVE) && (src != dst))) l = l + 1;
`endif
        return l;
    endfunction

    // Update the reference registers and push the expected response; call with the request driven, before the accept edge.
    task automatic expect_req(input logic [1:0] op, input logic [2:0] src, input logic [2:0] dst, input logic [15:0] imm, input logic err);
        exp_t e;
        logic [DW-1:0] v;
        if (!err) begin
            case (op)
                OP_MOVE: begin
                    v = ref_regs[src];
`ifdef REG_BUS_CTRL_SCRUB_EN
                    if (src != dst) ref_regs[src] = 16'h0000;
`endif
                    ref_regs[dst] = v;
                end
                OP_LOAD: ref_regs[dst] = imm;
                default: begin
                    exp_rsp_data = ref_regs[src];
`ifdef REG_BUS_CTRL_SCRUB_EN
                    ref_regs[src] = 16'h0000;
`endif
                end
            endcase
        end
        e.err  = err;
        e.data = exp_rsp_data;
        e.due  = cyc + lat_of(op, src, dst, err);
        sbq.push_back(e);
    endtask

    task automatic send_req(input logic [1:0] op, input logic [2:0] src, input logic [2:0] dst, input logic [15:0] imm, input logic err);
        int g = 0;
        while ((req_ready !== 1'b1) && (g < 20)) begin tick(); g++; end
        if (req_ready !== 1'b1) begin
            chk("req_ready_wait", 32'(req_ready), 32'd1);
        end else begin
            req_valid = 1'b1; req_op = op; req_src = src; req_dst = dst; req_imm = imm;
            expect_req(op, src, dst, imm, err);
            tick();
            req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int g = 0;
        while ((sbq.size() != 0) && (g < 20)) begin tick(); g++; end
        if (sbq.size() != 0) begin
            n_vec++; n_bad++;
            $display("FAIL rsp_timeout: %0d responses outstanding, required 0", sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        int lat;
        rst = 1'b1; mdl_init = 1'b1;
        req_valid = 1'b0; req_valid6 = 1'b0;
        req_op = 2'b00; req_src = 3'd0; req_dst = 3'd0; req_imm = 16'h0000;
        exp_rsp_data = 16'h0000;
        for (int i = 0; i < NR; i++) ref_regs[i] = 16'h1000 + 16'(i);
        @(posedge clk); #1; cyc = 1;
        tick(); tick();
        rst = 1'b0; mdl_init = 1'b0;

        // Reset state
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_send", 32'(send_info_bus), 32'd0);
        chk("rst_save", 32'(save_info_bus), 32'd0);
        chk("rst_wdata", 32'(bus_wdata), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);

        // LOAD dst=2 imm=A5A5: one save cycle with the immediate on the bus
        send_req(OP_LOAD, 3'd0, 3'd2, 16'hA5A5, 1'b0);
        chk("load_save", 32'(save_info_bus), 32'h04);
        chk("load_wdata", 32'(bus_wdata), 32'hA5A5);
        chk("load_send", 32'(send_info_bus), 32'd0);
        chk("load_busy", 32'(req_ready), 32'd0);
        tick();
        chk("load_save_off", 32'(save_info_bus), 32'd0);
        drain();
        chk("ready_after_resp", 32'(req_ready), 32'd1);

        // MOVE 2->5: send[2], then save[5] carrying the source data
        send_req(OP_MOVE, 3'd2, 3'd5, 16'h0000, 1'b0);
        chk("move_send", 32'(send_info_bus), 32'h04);
        chk("move_no_save", 32'(save_info_bus), 32'd0);
        tick();
        chk("move_capt_send", 32'(send_info_bus), 32'd0);
        tick();
        chk("move_save", 32'(save_info_bus), 32'h20);
        chk("move_wdata", 32'(bus_wdata), 32'hA5A5);
        drain();

        // Table of requests
        vt[0]  = '{OP_LOAD, 3'd0, 3'd0, 16'h1234, 1'b0};
        vt[1]  = '{OP_LOAD, 3'd0, 3'd7, 16'hFFFF, 1'b0};
        vt[2]  = '{OP_LOAD, 3'd0, 3'd3, 16'h0F0F, 1'b0};
        vt[3]  = '{OP_READ, 3'd5, 3'd0, 16'h0000, 1'b0};
        vt[4]  = '{OP_READ, 3'd0, 3'd0, 16'h0000, 1'b0};
        vt[5]  = '{OP_MOVE, 3'd3, 3'd3, 16'h0000, 1'b0};
        vt[6]  = '{OP_READ, 3'd3, 3'd0, 16'h0000, 1'b0};
        vt[7]  = '{OP_MOVE, 3'd7, 3'd1, 16'h0000, 1'b0};
        vt[8]  = '{OP_READ, 3'd1, 3'd0, 16'h0000, 1'b0};
        vt[9]  = '{OP_RSVD, 3'd1, 3'd1, 16'h5555, 1'b1};
        vt[10] = '{OP_READ, 3'd2, 3'd0, 16'h0000, 1'b0};
        vt[11] = '{OP_READ, 3'd6, 3'd0, 16'h0000, 1'b0};
        vt[12] = '{OP_LOAD, 3'd0, 3'd4, 16'h0000, 1'b0};
        vt[13] = '{OP_READ, 3'd4, 3'd0, 16'h0000, 1'b0};
        for (int k = 0; k < 14; k++) begin
            send_req(vt[k].op, vt[k].src, vt[k].dst, vt[k].imm, vt[k].err);
            if (vt[k].err) chk("err_no_strobe", 32'({send_info_bus, save_info_bus}), 32'd0);
            drain();
        end

        // READ 5 with req_valid held high: no second accept while busy
        req_valid = 1'b1; req_op = OP_READ; req_src = 3'd5; req_dst = 3'd0;
        lat = lat_of(OP_READ, 3'd5, 3'd0, 1'b0);
        expect_req(OP_READ, 3'd5, 3'd0, 16'h0000, 1'b0);
        tick();
        req_src = 3'd0;
        for (int i = 0; i < lat; i++) begin
            chk("hold_busy_ready", 32'(req_ready), 32'd0);
            tick();
        end
        req_valid = 1'b0;
        chk("hold_no_reaccept", 32'(req_ready), 32'd1);
        tick(); tick();
        drain();

        // Out-of-range source on a six-slot controller
        chk("n6_ready", 32'(req_ready6), 32'd1);
        req_valid6 = 1'b1; req_op = OP_READ; req_src = 3'd7; req_dst = 3'd0;
        tick();
        req_valid6 = 1'b0;
        chk("n6_rsp_valid", 32'(rsp_valid6), 32'd1);
        chk("n6_rsp_err", 32'(rsp_err6), 32'd1);
        chk("n6_no_strobe", 32'({send6, save6}), 32'd0);
        tick();
        chk("n6_rsp_pulse", 32'(rsp_valid6), 32'd0);

        // Reset during RD_CAPT of MOVE 2->7: transfer abandoned, no response
        req_valid = 1'b1; req_op = OP_MOVE; req_src = 3'd2; req_dst = 3'd7; req_imm = 16'h0000;
        tick();
        req_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_rsp_data = 16'h0000;
        chk("midrst_send", 32'(send_info_bus), 32'd0);
        chk("midrst_save", 32'(save_info_bus), 32'd0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd1);
        chk("midrst_rsp_data", 32'(rsp_data), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midrst_quiet_save", 32'(save_info_bus), 32'd0);
        end

        // Final register contents against the reference model
        for (int i = 0; i < NR; i++) chk($sformatf("reg%0d", i), 32'(mem[i]), 32'(ref_regs[i]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
